// File: rtl/mac_accum_pipe.sv
// Two-stage pipelined multiply-accumulate: stage 1 registers a*b, stage 2 adds it into
// the accumulator with optional saturation, sticky overflow and a saturating term counter.
module mac_accum_pipe #(
    parameter int unsigned IN_W   = 4,
    parameter int unsigned ACC_W  = 8,
    parameter bit          SIGNED = 1'b0,
    parameter bit          SAT    = 1'b1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             clr,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    output logic [ACC_W-1:0] mac_out,
    output logic             out_valid,
    output logic             ovf,
    output logic [CNT_W-1:0] term_cnt
);

    localparam int unsigned P_W = 2 * IN_W;

    // Stage 1 registers
    logic [P_W-1:0]   p_q, p_d;
    logic             v1_q, c1_q;

    // Stage 2 registers
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q;

    // Operands extended to the product width; the low P_W bits of the product are then
    // correct for both signed and unsigned interpretations.
    logic [P_W-1:0] a_ext, b_ext;

    always_comb begin
        a_ext = {{IN_W{SIGNED & a[IN_W-1]}}, a};
        b_ext = {{IN_W{SIGNED & b[IN_W-1]}}, b};
        p_d   = a_ext * b_ext;
    end

    // Product widened to the accumulator width
    logic [ACC_W-1:0] addend;
    logic             fill;

    assign fill = SIGNED & p_q[P_W-1];

    if (ACC_W > P_W) begin : g_ext
        assign addend = {{(ACC_W - P_W){fill}}, p_q};
    end else begin : g_no_ext
        assign addend = p_q;
        logic unused_fill;
        assign unused_fill = fill;
    end

    logic [ACC_W:0]   sum;
    logic             add_ovf;
    logic [ACC_W-1:0] rail;
    logic [ACC_W-1:0] acc_add;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, addend};

        if (SIGNED) begin
            add_ovf = (acc_q[ACC_W-1] == addend[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_q[ACC_W-1]);
            // Both addends share a sign on overflow, so the accumulator sign picks the rail
            rail    = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            add_ovf = sum[ACC_W];
            rail    = {ACC_W{1'b1}};
        end

        acc_add = (SAT && add_ovf) ? rail : sum[ACC_W-1:0];
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        cnt_d = cnt_q;

        if (c1_q) begin
            acc_d = v1_q ? addend : '0;
            cnt_d = v1_q ? CNT_W'(1) : '0;
            ovf_d = 1'b0;
        end else if (v1_q) begin
            acc_d = acc_add;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | add_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_q         <= '0;
            v1_q        <= 1'b0;
            c1_q        <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            v1_q        <= in_valid;
            c1_q        <= clr;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= v1_q;
        end
    end

    assign mac_out   = acc_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign term_cnt  = cnt_q;

endmodule

// File: tb/tb_mac_accum_pipe.sv
// Bench for mac_accum_pipe: three configurations (unsigned saturating, unsigned wrapping,
// signed saturating) share one stimulus stream and are checked against an integer model.
module tb_mac_accum_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       clr;
    logic [3:0] a;
    logic [3:0] b;

    logic [7:0] mac_w [3];
    logic       ov_w  [3];
    logic       ovf_w [3];
    logic [7:0] cnt_w [3];

    int errors = 0;
    int checks = 0;

    mac_accum_pipe #(.IN_W(4), .ACC_W(8), .SIGNED(1'b0), .SAT(1'b1), .CNT_W(8)) u_usat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .clr(clr), .a(a), .b(b),
        .mac_out(mac_w[0]), .out_valid(ov_w[0]), .ovf(ovf_w[0]), .term_cnt(cnt_w[0])
    );

    mac_accum_pipe #(.IN_W(4), .ACC_W(8), .SIGNED(1'b0), .SAT(1'b0), .CNT_W(8)) u_uwrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .clr(clr), .a(a), .b(b),
        .mac_out(mac_w[1]), .out_valid(ov_w[1]), .ovf(ovf_w[1]), .term_cnt(cnt_w[1])
    );

    mac_accum_pipe #(.IN_W(4), .ACC_W(8), .SIGNED(1'b1), .SAT(1'b1), .CNT_W(8)) u_ssat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .clr(clr), .a(a), .b(b),
        .mac_out(mac_w[2]), .out_valid(ov_w[2]), .ovf(ovf_w[2]), .term_cnt(cnt_w[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state per configuration; the accumulator is a plain integer in its natural range
    int m_acc [3];
    bit m_ovf [3];
    int m_cnt [3];
    bit m_ov  [3];

    // Pair sampled at the previous edge, waiting for its accumulate edge
    bit s_v, s_c;
    int s_pu, s_ps;

    function automatic void check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endfunction

    function automatic void model_add(int cfg, bit v, bit c, int prod);
        int lo, hi, s;
        bit sat;
        lo  = (cfg == 2) ? -128 : 0;
        hi  = (cfg == 2) ? 127 : 255;
        sat = (cfg != 1);
        if (c) begin
            m_acc[cfg] = v ? prod : 0;
            m_cnt[cfg] = v ? 1 : 0;
            m_ovf[cfg] = 1'b0;
        end else if (v) begin
            s = m_acc[cfg] + prod;
            if (s > hi) begin
                m_ovf[cfg] = 1'b1;
                s = sat ? hi : s - 256;
            end else if (s < lo) begin
                m_ovf[cfg] = 1'b1;
                s = sat ? lo : s + 256;
            end
            m_acc[cfg] = s;
            if (m_cnt[cfg] < 255) m_cnt[cfg]++;
        end
        m_ov[cfg] = v;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int i = 0; i < 3; i++) begin
                    m_acc[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0; m_ov[i] = 0;
                end
                s_v = 0; s_c = 0; s_pu = 0; s_ps = 0;
            end else begin
                for (int i = 0; i < 3; i++) model_add(i, s_v, s_c, (i == 2) ? s_ps : s_pu);
                s_v  = in_valid;
                s_c  = clr;
                s_pu = int'(a) * int'(b);
                s_ps = int'($signed(a)) * int'($signed(b));
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("model cfg%0d mac_out", i), int'(mac_w[i]), m_acc[i] & 255);
                check($sformatf("model cfg%0d out_valid", i), int'(ov_w[i]), int'(m_ov[i]));
                check($sformatf("model cfg%0d ovf", i), int'(ovf_w[i]), int'(m_ovf[i]));
                check($sformatf("model cfg%0d term_cnt", i), int'(cnt_w[i]), m_cnt[i]);
            end
        end
    end

    task automatic step(input bit v, input bit c, input logic [3:0] aa, input logic [3:0] bb);
        @(negedge clk);
        in_valid = v;
        clr      = c;
        a        = aa;
        b        = bb;
    endtask

    task automatic lit(input string nm, input int cfg, input int mac, input int cnt,
                       input bit of, input bit ov);
        check($sformatf("%s cfg%0d mac_out", nm, cfg), int'(mac_w[cfg]), mac);
        check($sformatf("%s cfg%0d term_cnt", nm, cfg), int'(cnt_w[cfg]), cnt);
        check($sformatf("%s cfg%0d ovf", nm, cfg), int'(ovf_w[cfg]), int'(of));
        check($sformatf("%s cfg%0d out_valid", nm, cfg), int'(ov_w[cfg]), int'(ov));
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; clr = 1'b0; a = '0; b = '0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) lit("reset", i, 0, 0, 1'b0, 1'b0);
        rst = 1'b1;

        // Basic stream
        step(1, 1, 4'd1, 4'd2);
        step(1, 0, 4'd3, 4'd10);
        step(1, 0, 4'd1, 4'd2);
        lit("basic0", 0, 2, 1, 0, 1);
        step(0, 0, 4'd0, 4'd0);
        lit("basic1", 0, 32, 2, 0, 1);
        step(0, 0, 4'd0, 4'd0);
        lit("basic2", 0, 34, 3, 0, 1);
        step(0, 0, 4'd0, 4'd0);
        lit("basic_hold", 0, 34, 3, 0, 0);

        // Saturation vs wrap, then clr alone
        step(1, 1, 4'd15, 4'd15);
        step(1, 0, 4'd15, 4'd15);
        step(0, 0, 4'd0, 4'd0);
        lit("sat0", 0, 225, 1, 0, 1);
        lit("wrap0", 1, 225, 1, 0, 1);
        lit("sgn_m1", 2, 1, 1, 0, 1);
        step(0, 1, 4'd0, 4'd0);
        lit("sat1", 0, 255, 2, 1, 1);
        lit("wrap1", 1, 194, 2, 1, 1);
        step(0, 0, 4'd0, 4'd0);
        step(0, 0, 4'd0, 4'd0);
        lit("clr_alone", 0, 0, 0, 0, 0);
        lit("clr_alone", 1, 0, 0, 0, 0);

        // Signed accumulation up to and off the positive rail
        step(1, 1, 4'd8, 4'd8);
        step(1, 0, 4'd3, 4'd14);
        step(1, 0, 4'd7, 4'd7);
        lit("sgn0", 2, 64, 1, 0, 1);
        step(1, 0, 4'd8, 4'd8);
        lit("sgn1", 2, 58, 2, 0, 1);
        step(0, 0, 4'd0, 4'd0);
        lit("sgn2", 2, 107, 3, 0, 1);
        step(1, 0, 4'd8, 4'd7);
        lit("sgn_rail", 2, 127, 4, 1, 1);
        step(0, 0, 4'd0, 4'd0);
        step(0, 0, 4'd0, 4'd0);
        lit("sgn_off_rail", 2, 71, 5, 1, 1);

        // Gaps and clr ordering
        step(1, 1, 4'd2, 4'd3);
        step(0, 0, 4'd0, 4'd0);
        step(1, 0, 4'd1, 4'd1);
        lit("gap0", 0, 6, 1, 0, 1);
        step(1, 1, 4'd4, 4'd4);
        lit("gap_idle", 0, 6, 1, 0, 0);
        step(0, 0, 4'd0, 4'd0);
        lit("gap1", 0, 7, 2, 0, 1);
        step(0, 0, 4'd0, 4'd0);
        lit("gap_clr", 0, 16, 1, 0, 1);

        // Long stream: counter saturation, rail hold, wrap
        step(1, 1, 4'd1, 4'd1);
        repeat (299) step(1, 0, 4'd1, 4'd1);
        step(0, 0, 4'd0, 4'd0);
        step(0, 0, 4'd0, 4'd0);
        lit("long", 0, 255, 255, 1, 1);
        lit("long", 1, 44, 255, 1, 1);
        lit("long", 2, 127, 255, 1, 1);

        // Asynchronous reset with pairs in flight
        step(1, 1, 4'd5, 4'd5);
        step(1, 0, 4'd2, 4'd2);
        step(1, 0, 4'd3, 4'd3);
        lit("pre_rst", 0, 25, 1, 0, 1);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) lit("async_rst", i, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; clr = 1'b0; rst = 1'b1;
        step(0, 0, 4'd0, 4'd0);
        step(0, 0, 4'd0, 4'd0);
        lit("post_rst", 0, 0, 0, 0, 0);
        step(1, 0, 4'd2, 4'd2);
        step(0, 0, 4'd0, 4'd0);
        step(0, 0, 4'd0, 4'd0);
        lit("restart", 0, 4, 1, 0, 1);
        step(0, 0, 4'd0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_accum_pipe.md
# mac_accum_pipe

Parametrised, pipelined multiply-accumulate unit, the successor to the fixed 4x4→8 MAC. It adds configurable operand and accumulator widths, signed or unsigned arithmetic, a valid qualifier, synchronous clear/load, optional saturation with a sticky overflow flag, and a term counter. It sits in the datapath wherever a running dot product is built from a stream of operand pairs, accepting one pair per clock with no back-pressure.

## Interface
- IN_W, default 4: operand width, a and b, ≥2.
- ACC_W, default 8: accumulator/output width; must be ≥ 2*IN_W.
- SIGNED, default 0: 1 = two's-complement operands and accumulator; 0 = unsigned.
- SAT, default 1: 1 = clamp on overflow; 0 = wrap modulo 2^ACC_W.
- CNT_W, default 8: term-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  a/b hold a pair to accumulate this cycle.
- clr  in  1  start a new accumulation.
- a  in  IN_W  multiplicand.
- b  in  IN_W  multiplier.
- mac_out  out  ACC_W  accumulator value.
- out_valid  out  1  one-cycle pulse; mac_out was just updated by a valid pair.
- ovf  out  1  sticky overflow/saturation flag since the last clr.
- term_cnt  out  CNT_W  number of valid pairs accumulated since the last clr; saturates at all-ones.

## Operation
- Stage 1 (multiply), on each edge:
  - Registers p = a*b at 2*IN_W bits, signed or unsigned per SIGNED.
  - Registers v1 = in_valid and c1 = clr.
- Stage 2 (accumulate), on each edge, using the stage-1 registers:
  - c1=1, v1=1: acc ← ext(p); term_cnt ← 1; ovf ← 0 (load, not add).
  - c1=1, v1=0: acc ← 0; term_cnt ← 0; ovf ← 0.
  - c1=0, v1=1: acc ← acc + ext(p); term_cnt ← term_cnt+1, held at max; ovf ← ovf | overflow.
  - c1=0, v1=0: all held.
- ext(p) sign-extends when SIGNED=1 and zero-extends otherwise, up to ACC_W.
- Overflow detection uses an ACC_W+1 bit sum.
  - Unsigned: overflow when the carry-out is set.
  - Signed: overflow when both addends have the same sign and the result sign differs.
- On overflow:
  - SAT=1: clamp to 2^ACC_W−1 (unsigned), to 2^(ACC_W−1)−1 (signed positive) or to −2^(ACC_W−1) (signed negative).
  - SAT=0: keep the wrapped sum.
  - ovf is set in both modes.
- a*b itself can never overflow, because ACC_W ≥ 2*IN_W.
- out_valid = registered v1, asserted together with the stage-2 update.

## Timing
- Latency 2 cycles. A pair sampled at edge E is multiplied at E, and its effect on mac_out, ovf, term_cnt and out_valid is visible after edge E+1.
- Throughput: one pair per cycle, back-to-back, with no stall and no ready signal.
- clr is pipelined with its pair, so it clears exactly at that pair's stage-2 edge. Pairs issued before the clr still finish accumulating into the old sum first.
- rst low, asynchronously:
  - mac_out=0, out_valid=0, ovf=0, term_cnt=0.
  - Pipeline registers (p, v1, c1) = 0.
  - A reset mid-stream discards in-flight pairs.
- Deassertion of rst is synchronous to clk. The first pair is accepted on the first edge with rst high.
- A saturated accumulator stays at the rail while further same-sign terms arrive. An opposite-sign term (signed mode) moves it off the rail normally.
- term_cnt stops at 2^CNT_W−1 and does not wrap.

## Test plan
- Defaults: assert rst low for 5 cycles, then stream (1,2), (3,10), (1,2) on consecutive cycles with clr on the first pair.
  - Expect mac_out = 2, 32, 34 on the three cycles after latency 2; out_valid high for 3 cycles; term_cnt=3; ovf=0.
- Saturation (defaults): clr+(15,15), then (15,15).
  - Expect mac_out = 225, then 255; ovf=1; term_cnt=2.
  - Then clr alone: mac_out=0, ovf=0, term_cnt=0, out_valid=0.
- Wrap (SAT=0): same stimulus as the saturation case.
  - Expect mac_out = 225, then 194 (450 mod 256); ovf=1.
- Signed (SIGNED=1, IN_W=4, ACC_W=8): clr+(−8,−8), (3,−2), (7,7).
  - Expect 64, 58, then 107. Then (−8,−8): 171 exceeds 127, so expect 127 with ovf=1.
- Gaps and clr ordering: (2,3), idle, (1,1), then clr+(4,4) the next cycle.
  - Expect 6, hold, 7, 16; out_valid shows no pulse on the idle cycle; term_cnt=1 after the clr.
- Reset mid-op: drive rst low asynchronously between edges while two pairs are in flight.
  - Expect all outputs 0 immediately; no out_valid after release until new pairs arrive.
